// File: rtl/data_bus_responder_if.sv
// Data-bus interface between the CPU MEM stage (master) and the responder (slave).
`timescale 1ns/1ps
interface data_bus_responder_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        timer_irq_o;

  modport master (
    output ce_i, we_i, addr_i, sel_i, wdata_i, tx_ready_i,
    input  rdata_o, tx_data_o, tx_valid_o, timer_irq_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, sel_i, wdata_i, tx_ready_i,
    output rdata_o, tx_data_o, tx_valid_o, timer_irq_o
  );
endinterface

// File: rtl/data_bus_responder.sv
// Memory-side responder: byte-lane-writable word RAM plus an MMIO page with a
// free-running cycle counter, compare/interrupt register and console TX FIFO.
`timescale 1ns/1ps
module data_bus_responder #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  data_bus_responder_if.slave  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] OFF_CYCLE  = 2'd0;
  localparam logic [1:0] OFF_CMP    = 2'd1;
  localparam logic [1:0] OFF_TXDATA = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  logic [31:0]       mem [(1 << ADDR_W)];
  logic [7:0]        fifo [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              ovf;
  logic [31:0]       cycle;
  logic [31:0]       cmp;
  logic              irq;

  logic              is_mmio;
  logic [1:0]        off;
  logic [ADDR_W-1:0] widx;
  logic              wr;
  logic              rd;
  logic              ram_wr;
  logic              cmp_wr;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              ovf_clr;
  logic              full;
  logic              empty;
  logic [31:0]       status;
  logic [31:0]       rdata;
  logic              unused_addr;

  assign is_mmio  = (bus.addr_i[31:28] == 4'h1);
  assign off      = bus.addr_i[3:2];
  assign widx     = bus.addr_i[ADDR_W+1:2];
  assign wr       = bus.ce_i & bus.we_i;
  assign rd       = bus.ce_i & ~bus.we_i;
  assign ram_wr   = wr & ~is_mmio;
  assign cmp_wr   = wr & is_mmio & (off == OFF_CMP);
  assign push_req = wr & is_mmio & (off == OFF_TXDATA) & bus.sel_i[0];
  assign ovf_clr  = wr & is_mmio & (off == OFF_STATUS) & bus.sel_i[0] & bus.wdata_i[2];

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // Fullness is judged before this cycle's pop, so a push at full is dropped even if a pop frees a slot.
  assign push     = push_req & ~full;
  assign pop      = ~empty & bus.tx_ready_i;

  assign status   = {24'b0, 4'(count), 1'b0, ovf, empty, full};

  assign unused_addr = ^{bus.addr_i[27:ADDR_W+2], bus.addr_i[1:0]};

  // RAM lane writes; not reset, and suppressed on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst && ram_wr) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (bus.sel_i[k]) mem[widx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
      end
    end
  end

  // Free-running cycle counter.
  always_ff @(posedge clk) begin
    if (rst) cycle <= '0;
    else     cycle <= cycle + 32'd1;
  end

  // Compare register with byte-lane writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp <= '0;
    end else if (cmp_wr) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (bus.sel_i[k]) cmp[8*k +: 8] <= bus.wdata_i[8*k +: 8];
      end
    end
  end

  // Sticky compare-match interrupt; a CMP write takes priority over a match.
  always_ff @(posedge clk) begin
    if (rst)                            irq <= 1'b0;
    else if (cmp_wr)                    irq <= 1'b0;
    else if (cycle == cmp && cmp != '0) irq <= 1'b1;
  end

  // FIFO storage; contents beyond the occupied slots are don't-care.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= bus.wdata_i[7:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)                   ovf <= 1'b0;
    else if (push_req && full) ovf <= 1'b1;
    else if (ovf_clr)          ovf <= 1'b0;
  end

  // Combinational read mux; zero unless a read is requested.
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (is_mmio) begin
        case (off)
          OFF_CYCLE:  rdata = cycle;
          OFF_CMP:    rdata = cmp;
          OFF_TXDATA: rdata = '0;
          default:    rdata = status;
        endcase
      end else begin
        rdata = mem[widx];
      end
    end
  end

  assign bus.rdata_o     = rdata;
  assign bus.tx_valid_o  = ~empty;
  assign bus.tx_data_o   = empty ? '0 : fifo[rd_ptr];
  assign bus.timer_irq_o = irq;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed testbench for data_bus_responder.
`timescale 1ns/1ps
module tb_data_bus_responder;

  localparam int          ADDR_W = 10;
  localparam logic [31:0] A_CYC  = 32'h1000_0000;
  localparam logic [31:0] A_CMP  = 32'h1000_0004;
  localparam logic [31:0] A_TXD  = 32'h1000_0008;
  localparam logic [31:0] A_STAT = 32'h1000_000C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  data_bus_responder_if bus();

  data_bus_responder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.ce_i    = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.sel_i   = '0;
    bus.wdata_i = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.sel_i = s; bus.wdata_i = d;
    #1;
    check("wr_rdata_zero", bus.rdata_o, 32'h0);
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a; bus.sel_i = 4'hF;
    #1;
    d = bus.rdata_o;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic drain_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'b0, bus.tx_valid_o}, 32'h1);
    check({tag, "_data"}, {24'b0, bus.tx_data_o}, {24'b0, exp});
    bus.tx_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready_i = 1'b0;
  endtask

  logic [7:0] got_q[$];

  initial begin
    bus_idle();
    bus.tx_ready_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'b0, bus.tx_valid_o}, 32'h0);
    check("rst_tx_data", {24'b0, bus.tx_data_o}, 32'h0);
    check("rst_irq", {31'b0, bus.timer_irq_o}, 32'h0);
    check("rst_rdata", bus.rdata_o, 32'h0);
    rst = 1'b0;

    // Counter / compare interrupt
    read_check("cycle0", A_CYC, 32'd0);
    bus_write(A_CMP, 4'hF, 32'd20);
    read_check("cmp_alias", 32'h1000_0014, 32'd20);
    for (int n = 3; n <= 24; n++) begin
      check("irq_n", {31'b0, bus.timer_irq_o}, (n >= 21) ? 32'h1 : 32'h0);
      read_check("cycle_n", A_CYC, n);
    end
    bus_write(A_CMP, 4'hF, 32'd0);
    check("irq_clear", {31'b0, bus.timer_irq_o}, 32'h0);
    bus_write(A_CMP, 4'hF, 32'd30);
    repeat (3) @(posedge clk);
    #1;
    check("irq_before_match", {31'b0, bus.timer_irq_o}, 32'h0);
    bus_write(A_CMP, 4'hF, 32'd100);
    check("irq_write_wins", {31'b0, bus.timer_irq_o}, 32'h0);
    read_check("cycle31", A_CYC, 32'd31);
    bus_write(A_CMP, 4'b0001, 32'h0000_0055);
    read_check("cmp_lane", A_CMP, 32'h0000_0055);
    bus_write(A_CMP, 4'hF, 32'd0);

    // RAM byte lanes and aliasing
    bus_write(32'h40, 4'hF, 32'hAABB_CCDD);
    bus_write(32'h40, 4'b0010, 32'h1122_3344);
    read_check("ram_lanes", 32'h40, 32'hAABB_33DD);
    read_check("ram_alias", 32'h40 + (32'd4 << ADDR_W), 32'hAABB_33DD);
    read_check("ram_byteaddr", 32'h43, 32'hAABB_33DD);
    bus.addr_i = 32'h40;
    #1;
    check("ce_low_rdata", bus.rdata_o, 32'h0);
    bus_idle();

    // FIFO fill, overflow, drain
    bus_write(A_TXD, 4'b0010, 32'h55);
    read_check("txd_nosel", A_STAT, 32'h02);
    for (int i = 0; i < 5; i++) bus_write(A_TXD, 4'b0001, 32'h41 + i);
    read_check("fifo_full_ovf", A_STAT, 32'h45);
    read_check("txd_reads0", A_TXD, 32'h0);
    drain_check("drain_a", 8'h41);
    drain_check("drain_b", 8'h42);
    drain_check("drain_c", 8'h43);
    drain_check("drain_d", 8'h44);
    check("drained_valid", {31'b0, bus.tx_valid_o}, 32'h0);
    read_check("drained_stat", A_STAT, 32'h06);
    bus_write(A_STAT, 4'b0001, 32'h4);
    read_check("ovf_cleared", A_STAT, 32'h02);

    // Push visible only the cycle after the write
    bus_write(A_TXD, 4'b0001, 32'h10);
    check("push_visible", {23'b0, bus.tx_valid_o, bus.tx_data_o}, 32'h110);
    for (int i = 1; i < 4; i++) bus_write(A_TXD, 4'b0001, 32'h10 + i);
    read_check("full4", A_STAT, 32'h41);
    bus.tx_ready_i = 1'b1;
    bus_write(A_TXD, 4'b0001, 32'h14);
    bus.tx_ready_i = 1'b0;
    read_check("push_pop_full", A_STAT, 32'h34);
    drain_check("pp_b", 8'h11);
    drain_check("pp_c", 8'h12);
    drain_check("pp_d", 8'h13);
    bus_write(A_STAT, 4'b0001, 32'h4);
    read_check("pp_empty", A_STAT, 32'h02);

    // Backpressure with random ready
    got_q.delete();
    fork
      begin : producer
        logic [31:0] s;
        for (int i = 0; i < 16; i++) begin
          int tries;
          tries = 0;
          do begin
            bus_read(A_STAT, s);
            tries++;
          end while (s[0] && tries < 100);
          check("bp_space", {31'b0, s[0]}, 32'h0);
          bus_write(A_TXD, 4'b0001, 32'h60 + i);
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
      end
      begin : consumer
        logic       stalled;
        logic [7:0] held;
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < 3000 && got_q.size() < 16; c++) begin
          @(negedge clk);
          if (stalled) check("bp_stable", {24'b0, bus.tx_data_o}, {24'b0, held});
          bus.tx_ready_i = 1'($urandom_range(0, 1));
          if (bus.tx_valid_o && bus.tx_ready_i) got_q.push_back(bus.tx_data_o);
          stalled = bus.tx_valid_o && !bus.tx_ready_i;
          held    = bus.tx_data_o;
        end
        @(posedge clk); #1;
        bus.tx_ready_i = 1'b0;
      end
    join
    check("bp_count", got_q.size(), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check("bp_order", {24'b0, got_q[i]}, 32'h60 + i);
    read_check("bp_end_stat", A_STAT, 32'h02);

    // Reset mid-stream with a colliding RAM write
    for (int i = 0; i < 3; i++) bus_write(A_TXD, 4'b0001, 32'h70 + i);
    bus_write(A_CMP, 4'hF, 32'd7);
    bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h40; bus.sel_i = 4'hF;
    bus.wdata_i = 32'hDEAD_BEEF;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_idle();
    check("mid_rst_valid", {31'b0, bus.tx_valid_o}, 32'h0);
    check("mid_rst_data", {24'b0, bus.tx_data_o}, 32'h0);
    read_check("mid_rst_cycle", A_CYC, 32'd0);
    read_check("mid_rst_stat", A_STAT, 32'h02);
    read_check("mid_rst_cmp", A_CMP, 32'h0);
    read_check("mid_rst_ram", 32'h40, 32'hAABB_33DD);
    check("mid_rst_irq", {31'b0, bus.timer_irq_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Memory-side responder for the core's data port: it answers `ram_*` bus requests from the CPU's MEM stage. It provides a byte-lane-writable word RAM and a small MMIO page. The page holds a free-running cycle counter, a compare/interrupt register and a console TX FIFO drained over a valid/ready handshake. It sits at the top level beside the instruction ROM, wired directly to the CPU's data-bus outputs and `ram_data_i` input.

## Interface
- `ADDR_W`, 10: RAM word-index width; RAM holds 2^ADDR_W 32-bit words.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, ≥2.

- `clk` in 1: the single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ce_i` in 1: request valid (from `ram_ce_o`).
- `we_i` in 1: 1 = write, 0 = read (from `ram_we_o`).
- `addr_i` in 32: byte address (from `ram_addr_o`).
- `sel_i` in 4: byte lanes; `sel_i[k]` covers `data[8k+7:8k]`.
- `wdata_i` in 32: write data (from `ram_data_o`).
- `rdata_o` out 32: read data (to `ram_data_i`).
- `tx_data_o` out 8: FIFO head byte.
- `tx_valid_o` out 1: FIFO non-empty.
- `tx_ready_i` in 1: consumer accepts head byte.
- `timer_irq_o` out 1: sticky compare-match interrupt.

## Operation
- Decode: `addr_i[31:28]==4'h1` selects MMIO, using offset `addr_i[3:2]`. All other addresses select RAM at word index `addr_i[ADDR_W+1:2]`; higher bits are ignored, so the RAM aliases/wraps.
- `addr_i[1:0]` is ignored; byte placement is carried only by `sel_i`.
- RAM write: on the edge where `ce_i & we_i`, each lane k with `sel_i[k]` set is written; other lanes are kept.
- RAM read: combinational full word, lanes not masked. RAM contents are not reset.
- MMIO offset 0x0 CYCLE (RO): 32-bit counter. It is 0 in the first cycle after reset and +1 per cycle, wrapping 0xFFFFFFFF→0. Writes are ignored.
- MMIO offset 0x4 CMP (RW): writes are byte-lane masked.
  - `timer_irq_o` sets on the edge where CYCLE==CMP and CMP≠0.
  - Any write to CMP clears `timer_irq_o`; a write in a match cycle wins, so irq ends 0.
- MMIO offset 0x8 TXDATA (WO, reads 0): a write with `sel_i[0]` pushes `wdata_i[7:0]`.
  - A push while full (occupancy evaluated before this cycle's pop) is dropped and sets sticky OVF.
  - A write without `sel_i[0]` is ignored.
- MMIO offset 0xC STATUS: bit0 full, bit1 empty, bit2 OVF, bits[7:4] occupancy count, other bits 0.
  - Writing 1 to bit2 with `sel_i[0]` clears OVF; a simultaneous new overflow wins (OVF stays 1).
- Pop: on the edge where `tx_valid_o & tx_ready_i`, the FIFO advances.
  - Push and pop in the same cycle with the FIFO non-full: both occur, count unchanged.
  - Push to an empty FIFO is not visible on `tx_data_o` until the next cycle (no bypass).
- `ce_i` low: `rdata_o`=0 and no state change except the counter, irq and FIFO pop.
- Unused MMIO offsets in the page alias by `addr_i[3:2]`.

## Timing
- Reads have 0 latency: `rdata_o` is combinational from `ce_i/we_i/addr_i` and current state. During writes (`we_i`=1) `rdata_o`=0.
- Writes commit at the request edge. A read of the same location one cycle later returns the new value.
- Reset values: `rdata_o` 0 (ce low), `tx_valid_o` 0, `tx_data_o` 0, `timer_irq_o` 0, CYCLE 0, CMP 0, OVF 0, FIFO empty.
- Reset asserted mid-operation: same-edge bus writes are not performed, the FIFO is flushed, and RAM keeps its contents.
- `tx_data_o`/`tx_valid_o` are registered-state outputs. `tx_data_o` is stable while `tx_valid_o & ~tx_ready_i`.

## Test plan
- RAM byte lanes: write 0xAABBCCDD sel 1111 to 0x40, then 0x11223344 sel 0010 → read 0x40 returns 0xAABB33DD; read 0x40+(4<<ADDR_W) returns the same (alias).
- Counter/irq: reset, write CMP=20 → `timer_irq_o` rises on edge where CYCLE==20 and stays high; CMP write of 0 clears it; CYCLE read at cycle n returns n.
- FIFO fill/overflow: push 'A','B','C','D','E' with `tx_ready_i`=0 → STATUS=0x41|0x4 (full, OVF, count 4); drain yields A,B,C,D then `tx_valid_o`=0, STATUS bit1=1.
- Simultaneous push/pop at full: count 4, push + pop same edge → push dropped, OVF set, count 3.
- Backpressure: toggle `tx_ready_i` randomly while pushing 16 bytes → output sequence identical, `tx_data_o` stable while stalled.
- Reset mid-stream: 3 bytes queued, assert `rst` one cycle → `tx_valid_o` 0, CYCLE 0, RAM word previously written still readable.
